// File: rtl/alu_pipe.sv
// Two-stage, flow-controlled ALU with a result FIFO.
// Input stalling uses credits, so a result reaching stage 2 always finds a free FIFO slot.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushin,
    output logic             stopout,
    input  logic [2:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             pushout,
    input  logic             stopin,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam int EW = WIDTH + 2;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             ci_q, ci_d;
    op_e              ctl_q, ctl_d;
    logic             s1_valid_q, s1_valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             stopout_q, stopout_d;
    logic [EW-1:0]    mem_q [DEPTH];

    logic             in_xfer, out_xfer;
    logic [OW-1:0]    occ, occ_next;
    logic [WIDTH-1:0] b_op, res_z;
    logic [WIDTH:0]   sum;
    logic             res_c, res_o;
    logic [EW-1:0]    head;

    assign in_xfer  = pushin & ~stopout_q;
    assign pushout  = (count_q != '0);
    assign out_xfer = pushout & ~stopin;
    assign stopout  = stopout_q;

    // Stage 2: subtraction is a + ~b + ci, so overflow uses the inverted operand
    always_comb begin
        b_op  = (ctl_q == OP_SUB) ? ~b_q : b_q;
        sum   = {1'b0, a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, ci_q};
        res_z = '0;
        res_c = 1'b0;
        res_o = 1'b0;
        case (ctl_q)
            OP_ADD, OP_SUB: begin
                res_z = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_o = (a_q[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  res_z = a_q & b_q;
            OP_OR:   res_z = a_q | b_q;
            OP_XOR:  res_z = a_q ^ b_q;
            OP_SHL: begin
                res_z = {a_q[WIDTH-2:0], ci_q};
                res_c = a_q[WIDTH-1];
            end
            OP_SHR: begin
                res_z = {ci_q, a_q[WIDTH-1:1]};
                res_c = a_q[0];
            end
            default: res_z = a_q;
        endcase
    end

    always_comb begin
        a_d        = in_xfer ? a : a_q;
        b_d        = in_xfer ? b : b_q;
        ci_d       = in_xfer ? ci : ci_q;
        ctl_d      = in_xfer ? op_e'(ctl) : ctl_q;
        s1_valid_d = in_xfer;
        wr_ptr_d   = s1_valid_q ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = out_xfer ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(s1_valid_q) - CW'(out_xfer);
        // Occupancy counts the result still in stage 1 as already holding a slot
        occ        = OW'(count_q) + OW'(s1_valid_q);
        occ_next   = occ + OW'(in_xfer) - OW'(out_xfer);
        stopout_d  = (occ_next >= OW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            ci_q       <= 1'b0;
            ctl_q      <= OP_ADD;
            s1_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stopout_q  <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            ci_q       <= ci_d;
            ctl_q      <= ctl_d;
            s1_valid_q <= s1_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stopout_q  <= stopout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            mem_q[wr_ptr_q] <= {res_z, res_c, res_o};
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign z    = pushout ? head[EW-1:2] : '0;
    assign cout = pushout ? head[1] : 1'b0;
    assign ovf  = pushout ? head[0] : 1'b0;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, back-pressure,
// mid-operation reset and a randomized stream against a scoreboard.
module tb_alu_pipe;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         pushin, stopout, ci, pushout, stopin, cout, ovf;
    logic [2:0]   ctl;
    logic [W-1:0] a, b, z;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .pushin(pushin), .stopout(stopout),
        .ctl(ctl), .a(a), .b(b), .ci(ci), .pushout(pushout),
        .stopin(stopin), .z(z), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [2:0] ctl;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] ez;
        logic       ec;
        logic       eo;
    } vec_t;

    typedef struct {
        logic [7:0] z;
        logic       c;
        logic       o;
    } res_t;

    vec_t vecs[14];
    res_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   occ_m = 0;
    bit   last_in, last_out;

    // Reference: plain integer arithmetic, overflow from signed-range check
    function automatic res_t ref_model(input int op, input int av, input int bv, input int civ);
        res_t r;
        int bb, s, sa, sb, sr;
        r.z = 8'h00;
        r.c = 1'b0;
        r.o = 1'b0;
        case (op)
            0, 1: begin
                bb  = (op == 1) ? 255 - bv : bv;
                s   = av + bb + civ;
                r.z = 8'(s % 256);
                r.c = (s > 255);
                sa  = (av > 127) ? av - 256 : av;
                sb  = (bb > 127) ? bb - 256 : bb;
                sr  = sa + sb + civ;
                r.o = (sr > 127) || (sr < -128);
            end
            2: r.z = 8'(av & bv);
            3: r.z = 8'(av | bv);
            4: r.z = 8'(av ^ bv);
            5: begin
                r.z = 8'((av * 2 + civ) % 256);
                r.c = (av > 127);
            end
            6: begin
                r.z = 8'(av / 2 + civ * 128);
                r.c = ((av % 2) == 1);
            end
            default: r.z = 8'(av);
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic randomize_inputs();
        ctl = 3'($urandom_range(0, 7));
        a   = 8'($urandom_range(0, 255));
        b   = 8'($urandom_range(0, 255));
        ci  = 1'($urandom_range(0, 1));
    endtask

    // One clock: decide transfers at the falling edge, score pops, then step past the rising edge
    task automatic step();
        res_t e;
        @(negedge clk);
        last_in  = pushin && !stopout;
        last_out = pushout && !stopin;
        if (last_out) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got z=%0h want no result", z);
            end else begin
                e = exp_q.pop_front();
                $display("pop z=%02h cout=%0b ovf=%0b (want %02h %0b %0b)", z, cout, ovf, e.z, e.c, e.o);
                chk("pop_z", z, e.z);
                chk("pop_cout", cout, e.c);
                chk("pop_ovf", ovf, e.o);
            end
        end
        if (last_in) exp_q.push_back(ref_model(int'(ctl), int'(a), int'(b), int'(ci)));
        @(posedge clk);
        #1;
        occ_m = occ_m + int'(last_in) - int'(last_out);
        chk("occ_bound", (occ_m <= D), 1);
    endtask

    task automatic drain();
        int n;
        pushin = 1'b0;
        stopin = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || pushout) && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_pushout", pushout, 0);
    endtask

    task automatic run_vec(input int i);
        ctl    = vecs[i].ctl;
        a      = vecs[i].a;
        b      = vecs[i].b;
        ci     = vecs[i].ci;
        stopin = 1'b1;
        pushin = 1'b1;
        step();
        pushin = 1'b0;
        chk("vec_xfer", last_in, 1);
        chk("vec_lat_early", pushout, 0);
        step();
        chk("vec_pushout", pushout, 1);
        chk("vec_z", z, vecs[i].ez);
        chk("vec_cout", cout, vecs[i].ec);
        chk("vec_ovf", ovf, vecs[i].eo);
        stopin = 1'b0;
        step();
        stopin = 1'b1;
        chk("vec_empty_pushout", pushout, 0);
        chk("vec_empty_z", z, 0);
    endtask

    initial begin
        int cnt, n_done, cyc;
        vecs[0]  = '{3'd0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{3'd1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{3'd5, 8'h81, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[5]  = '{3'd6, 8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0};
        vecs[6]  = '{3'd4, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0};
        vecs[7]  = '{3'd7, 8'hA5, 8'h5A, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[8]  = '{3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[9]  = '{3'd3, 8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, 1'b0};
        vecs[10] = '{3'd1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[11] = '{3'd0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[12] = '{3'd6, 8'h00, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[13] = '{3'd0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        // Reset held with random activity
        rst = 1'b0;
        pushin = 1'b0;
        stopin = 1'b0;
        randomize_inputs();
        for (int i = 0; i < 5; i++) begin
            pushin = 1'($urandom_range(0, 1));
            stopin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("rst_outputs", {stopout, pushout, z, cout, ovf}, 0);
        end
        pushin = 1'b0;
        stopin = 1'b1;
        rst = 1'b1;

        // Directed vectors
        for (int i = 0; i < 14; i++) run_vec(i);

        // Back-pressure: fill with stopin held
        stopin = 1'b1;
        pushin = 1'b1;
        randomize_inputs();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_in) begin
                cnt++;
                randomize_inputs();
            end
        end
        chk("bp_transfers", cnt, 4);
        chk("bp_stopout_full", stopout, 1);
        stopin = 1'b0;
        step();
        chk("bp_one_pop", last_out, 1);
        chk("bp_no_xfer_while_full", last_in, 0);
        chk("bp_stopout_fall", stopout, 0);
        stopin = 1'b1;
        step();
        chk("bp_refill_xfer", last_in, 1);
        chk("bp_stopout_again", stopout, 1);
        drain();

        // Mid-operation reset: three results buffered plus one in stage 1
        stopin = 1'b1;
        pushin = 1'b1;
        randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            randomize_inputs();
        end
        chk("mr_full_before", stopout, 1);
        rst = 1'b0;
        #1;
        chk("mr_pushout_async", pushout, 0);
        chk("mr_z_async", z, 0);
        chk("mr_stopout_async", stopout, 0);
        exp_q.delete();
        occ_m = 0;
        pushin = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        stopin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_stale", pushout, 0);
        end
        run_vec(2);
        drain();

        // Randomized stream with random back-pressure
        n_done = 0;
        cyc = 0;
        pushin = 1'b0;
        while (n_done < 100 && cyc < 3000) begin
            if (!pushin || last_in) begin
                pushin = 1'($urandom_range(0, 1));
                randomize_inputs();
            end
            stopin = 1'($urandom_range(0, 1));
            step();
            if (last_in) n_done++;
            cyc++;
        end
        chk("stream_done", n_done, 100);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, flow-controlled ALU: accepts operand pairs over a push/stop handshake, computes one of eight operations in a two-stage pipeline, and buffers results in an internal FIFO so downstream back-pressure never drops data. It is the WIDTH/DEPTH-generalised successor of the 8-bit, 2-bit-opcode ALU, adding shift, xor and pass operations, a signed-overflow flag and credit-based input stalling.

## Interface
- WIDTH, 8, operand/result width (≥2)
- DEPTH, 4, result FIFO entries (power of 2, ≥2)
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset; asynchronous and active-low
- pushin  input  1  operand word valid
- stopout  output  1  block cannot accept; input transfer only when pushin=1 and stopout=0
- ctl  input  3  opcode
- a, b  input  WIDTH  operands
- ci  input  1  carry/shift-in
- pushout  output  1  result valid at FIFO head
- stopin  input  1  downstream hold; output transfer only when pushout=1 and stopin=0
- z  output  WIDTH  result
- cout  output  1  carry/shift-out
- ovf  output  1  signed overflow (add/sub only)

## Operation
- Opcodes (W=WIDTH):
  - 000 add: {cout,z} = a + b + ci; ovf = a[W-1]==b[W-1] && z[W-1]!=a[W-1]
  - 001 sub: {cout,z} = a + ~b + ci (ci=1 gives a−b; cout=1 means no borrow); ovf from the same formula using ~b
  - 010 and, 011 or, 100 xor: bitwise; cout=0, ovf=0
  - 101 shl: z = {a[W-2:0],ci}, cout = a[W-1]; ovf=0
  - 110 shr: z = {ci,a[W-1:1]}, cout = a[0]; ovf=0
  - 111 pass: z = a; cout=0, ovf=0
- All arithmetic modulo 2^W; b and ci ignored where unused.
- Stage S1: on input transfer, register a, b, ci, ctl and set s1_valid; otherwise clear s1_valid.
- Stage S2: when s1_valid, compute from S1 registers and write {z,cout,ovf} into the FIFO tail on the next edge. Writes are unconditional; credit accounting guarantees space.
- FIFO: DEPTH entries; read and write pointers wrap modulo DEPTH; count is 0..DEPTH. Pop on output transfer.
- Occupancy occ = count + s1_valid. occ_next = occ + in_xfer − out_xfer. stopout is registered: stopout <= (occ_next ≥ DEPTH). occ never exceeds DEPTH.
- pushout = (count ≠ 0). z/cout/ovf present the FIFO head when pushout=1 and drive 0 when pushout=0.
- Order preserved; no result is dropped or duplicated.

## Timing
- Reset asserted (rst=0, any time, asynchronous): pointers, count and s1_valid clear immediately. Outputs: stopout=0, pushout=0, z=0, cout=0, ovf=0. Any in-flight or buffered results are discarded.
- First edge after rst deasserts may accept input.
- Latency: input transferred at edge N; FIFO write at edge N+1; pushout=1 from after edge N+1, if the FIFO was empty. Throughput is one result per cycle when stopin=0.
- Stall: pushin while stopout=1 is ignored; the source holds its data.
- Full: with stopin=1, stopout rises after the edge that makes occ=DEPTH. It falls after the first edge at which occ_next<DEPTH.
- Simultaneous pop and S2 write on a full FIFO are legal; count is unchanged.
- Simultaneous input transfer and output transfer leave occ unchanged, and stopout holds its value.
- When stopin=1 and pushout=1, the head and its flags hold stable.

## Test plan
- Reset: hold rst=0 with random pushin/stopin -> all outputs 0; release, push add a=0x12 b=0x34 ci=0 -> 2 edges later pushout=1, z=0x46, cout=0, ovf=0.
- Arithmetic (WIDTH=8): add 0xFF+0x01 ci=0 -> z=0x00, cout=1, ovf=0; add 0x7F+0x01 -> z=0x80, cout=0, ovf=1; sub 0x05−0x07 ci=1 -> z=0xFE, cout=0, ovf=0.
- Shifts/logic: shl a=0x81 ci=1 -> z=0x03, cout=1; shr a=0x81 ci=0 -> z=0x40, cout=1; xor 0xF0^0x3C -> z=0xCC, cout=0; pass a=0xA5 -> z=0xA5.
- Back-pressure (DEPTH=4): stopin=1, pushin=1 every cycle -> exactly 4 transfers, stopout=1 after the 4th. Release stopin for one cycle -> one pop, stopout=0 one edge later, one more transfer. Results emerge in order.
- Streaming: 100 random ops with random stopin (50%) and random pushin -> scoreboard matches the reference model exactly, and occ never exceeds 4.
- Reset mid-operation: with 3 results buffered and s1_valid=1, pulse rst=0 -> pushout=0 immediately; after release no stale result appears and the next op returns the correct value.
